// File: rtl/chess_countdown.sv
// Two-player chess clock: per-player MM:SS countdown driven by a 1 Hz tick,
// with turn-end increment, pause/resume and time-out flagging.
module chess_countdown #(
    parameter int unsigned INIT_MIN = 5,
    parameter int unsigned INIT_SEC = 0,
    parameter int unsigned INC_SEC  = 0
) (
    input  logic       clkIn,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       btnA,
    input  logic       btnB,
    output logic [6:0] minA,
    output logic [6:0] minB,
    output logic [5:0] secA,
    output logic [5:0] secB,
    output logic       activeA,
    output logic       activeB,
    output logic       flagA,
    output logic       flagB,
    output logic       paused
);

    typedef enum logic [2:0] {IDLE, RUN_A, RUN_B, PAUSE, DONE} stateT;

    localparam logic [12:0] INIT_TIME = {7'(INIT_MIN), 6'(INIT_SEC)};
    localparam logic        INIT_ZERO = (INIT_MIN == 0) && (INIT_SEC == 0);

    stateT state;
    logic  sideIsB;

    // Time values are packed as {min[6:0], sec[5:0]}.
    function automatic logic [12:0] decTime(input logic [12:0] t);
        if (t[5:0] != 6'd0)
            return {t[12:6], t[5:0] - 6'd1};
        else if (t[12:6] != 7'd0)
            return {t[12:6] - 7'd1, 6'd59};
        else
            return '0;
    endfunction

    function automatic logic [12:0] addInc(input logic [12:0] t);
        logic [6:0] s;
        logic [7:0] m;
        s = {1'b0, t[5:0]} + 7'(INC_SEC);
        m = {1'b0, t[12:6]};
        if (s >= 7'd60) begin
            s = s - 7'd60;
            m = m + 8'd1;
        end
        if (m > 8'd99)
            return {7'd99, 6'd59};
        return {m[6:0], s[5:0]};
    endfunction

    logic [12:0] timeA, timeB;
    logic [12:0] decA, decB, decIncA, decIncB, incA, incB;

    assign timeA   = {minA, secA};
    assign timeB   = {minB, secB};
    assign decA    = decTime(timeA);
    assign decB    = decTime(timeB);
    assign decIncA = addInc(decA);
    assign decIncB = addInc(decB);
    assign incA    = addInc(timeA);
    assign incB    = addInc(timeB);

    always_ff @(posedge clkIn) begin
        if (rst) begin
            state        <= IDLE;
            sideIsB      <= 1'b0;
            {minA, secA} <= INIT_TIME;
            {minB, secB} <= INIT_TIME;
            activeA      <= 1'b0;
            activeB      <= 1'b0;
            flagA        <= 1'b0;
            flagB        <= 1'b0;
            paused       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (INIT_ZERO) begin
                            state <= DONE;
                            flagA <= 1'b1;
                        end else begin
                            state   <= RUN_A;
                            activeA <= 1'b1;
                        end
                    end
                end
                RUN_A: begin
                    if (pause) begin
                        state   <= PAUSE;
                        sideIsB <= 1'b0;
                        activeA <= 1'b0;
                        paused  <= 1'b1;
                    end else if (tick) begin
                        // Time-out wins over a same-cycle button press.
                        if (decA == '0) begin
                            {minA, secA} <= decA;
                            state        <= DONE;
                            activeA      <= 1'b0;
                            flagA        <= 1'b1;
                        end else if (btnA) begin
                            {minA, secA} <= decIncA;
                            state        <= RUN_B;
                            activeA      <= 1'b0;
                            activeB      <= 1'b1;
                        end else begin
                            {minA, secA} <= decA;
                        end
                    end else if (btnA) begin
                        {minA, secA} <= incA;
                        state        <= RUN_B;
                        activeA      <= 1'b0;
                        activeB      <= 1'b1;
                    end
                end
                RUN_B: begin
                    if (pause) begin
                        state   <= PAUSE;
                        sideIsB <= 1'b1;
                        activeB <= 1'b0;
                        paused  <= 1'b1;
                    end else if (tick) begin
                        if (decB == '0) begin
                            {minB, secB} <= decB;
                            state        <= DONE;
                            activeB      <= 1'b0;
                            flagB        <= 1'b1;
                        end else if (btnB) begin
                            {minB, secB} <= decIncB;
                            state        <= RUN_A;
                            activeB      <= 1'b0;
                            activeA      <= 1'b1;
                        end else begin
                            {minB, secB} <= decB;
                        end
                    end else if (btnB) begin
                        {minB, secB} <= incB;
                        state        <= RUN_A;
                        activeB      <= 1'b0;
                        activeA      <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        paused <= 1'b0;
                        if (sideIsB) begin
                            state   <= RUN_B;
                            activeB <= 1'b1;
                        end else begin
                            state   <= RUN_A;
                            activeA <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state        <= IDLE;
                        {minA, secA} <= INIT_TIME;
                        {minB, secB} <= INIT_TIME;
                        flagA        <= 1'b0;
                        flagB        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chess_countdown.md
CHESS_COUNTDOWN -- requirements
Module: chess_countdown

Interface
REQ-001 SHALL have parameter INIT_MIN, default 5, initial minutes per player (0..99).
REQ-002 SHALL have parameter INIT_SEC, default 0, initial seconds per player (0..59).
REQ-003 SHALL have parameter INC_SEC, default 0, increment in seconds added on turn end (0..59).
REQ-004 SHALL have port clkIn, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port tick, input, 1, one-cycle 1 Hz enable pulse from the frequency divider.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that starts the game or reloads after time-out.
REQ-008 SHALL have port pause, input, 1, one-cycle pulse that toggles pause.
REQ-009 SHALL have port btnA, input, 1, one-cycle pulse when player A ends a turn; input is already debounced.
REQ-010 SHALL have port btnB, input, 1, one-cycle pulse when player B ends a turn; input is already debounced.
REQ-011 SHALL have ports minA and minB, output, 7, remaining minutes for each player.
REQ-012 SHALL have ports secA and secB, output, 6, remaining seconds for each player.
REQ-013 SHALL have ports activeA and activeB, output, 1, set while that player's clock is counting.
REQ-014 SHALL have ports flagA and flagB, output, 1, set when that player's time has reached 00:00.
REQ-015 SHALL have port paused, output, 1, set while in PAUSE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN_A, RUN_B, PAUSE and DONE, plus a 1-bit side register that records which run state was paused.
REQ-017 In IDLE: start SHALL go to RUN_A next cycle; tick, btnA, btnB and pause SHALL be ignored; times SHALL hold their loaded values.
REQ-018 In RUN_A:
- each tick SHALL decrement player A's time by one second;
- a decrement from sec=0 SHALL give min-1, sec=59;
- player B's time SHALL hold.
REQ-019 In RUN_A: btnA SHALL go to RUN_B and add INC_SEC to player A's time, normalised to sec<60 with carry into min.
REQ-020 The increment SHALL saturate at 99:59.
REQ-021 RUN_B SHALL behave the same as RUN_A with A and B swapped.
REQ-022 btnB in RUN_A and btnA in RUN_B SHALL be ignored.
REQ-023 If tick and the active player's button occur in the same cycle, the decrement SHALL be applied first, then the increment and the turn switch.
REQ-024 If a tick takes the active player's time to 00:00, the FSM SHALL go to DONE and set that player's flag; a same-cycle button press SHALL be ignored (no increment, no switch).
REQ-025 pause in RUN_x SHALL go to PAUSE and record x in the side register; a same-cycle tick or button SHALL be ignored.
REQ-026 In PAUSE: pause SHALL return to the recorded RUN_x; tick, btnA and btnB SHALL be ignored.
REQ-027 In DONE: times and flags SHALL hold; start SHALL reload both players to INIT_MIN:INIT_SEC, clear the flags and go to IDLE; all other inputs SHALL be ignored.
REQ-028 Priority within one cycle SHALL be rst > pause > tick > button > start.
REQ-029 activeA SHALL be 1 only in RUN_A, activeB only in RUN_B, and paused only in PAUSE; these outputs SHALL be registered.
REQ-030 Time-register changes SHALL be visible on the outputs the cycle after the triggering input (latency of 1 cycle).
REQ-031 If INIT_MIN:INIT_SEC is 00:00, start SHALL go directly to DONE with flagA=1.

Reset
REQ-032 rst SHALL force, on the next edge and from any state including mid-turn or PAUSE:
- state = IDLE;
- minA = minB = INIT_MIN and secA = secB = INIT_SEC;
- flagA = flagB = activeA = activeB = paused = 0;
- side register = A.

Verification
REQ-033 Defaults; rst, start, 3 ticks -> minA=4, secA=57, activeA=1, minB=5, secB=0.
REQ-034 INC_SEC=5; RUN_A at 04:57, btnA -> minA=5, secA=2, activeB=1; then tick -> secB=59, minB=4.
REQ-035 INIT_MIN=0, INIT_SEC=2; start, 2 ticks, with btnA in the same cycle as the 2nd tick -> flagA=1, state DONE, activeB=0, minA=secA=0.
REQ-036 RUN_B; pause, then 5 ticks and btnB -> paused=1, times unchanged; pause again -> activeB=1 and counting resumes.
REQ-037 RUN_A at 03:10 and paused; rst -> both players 05:00, all flags, active and paused outputs 0; a following tick leaves the times unchanged.
REQ-038 DONE with flagB=1; start -> IDLE, flags cleared, both players 05:00; a further start -> RUN_A.
